// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and state type for the LFSR random-number generator
package lfsr_pkg;

   localparam int          RND_NUM_W = 8;
   localparam logic [15:0] TAPS      = 16'hB400;
   localparam logic [15:0] RND_SEED  = 16'h0001;

   localparam logic [15:0] DEF_TAPS  = TAPS;
   localparam logic [15:0] DEF_SEED  = RND_SEED;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } rng_state_t;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR register with step enable, seeded load and lock-up guard
module lfsr_core #(
   parameter int          W    = 16,
   parameter logic [W-1:0] TAPS = W'(lfsr_pkg::DEF_TAPS),
   parameter logic [W-1:0] SEED = W'(lfsr_pkg::DEF_SEED)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         step_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] state_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_o <= SEED;
      end else if (load_i) begin
         state_o <= (load_val_i == '0) ? SEED : load_val_i;
      end else if (state_o == '0) begin
         // an all-zero register can never leave zero on its own
         state_o <= SEED;
      end else if (step_i) begin
         state_o <= {state_o[W-2:0], ^(state_o & TAPS)};
      end
   end

endmodule

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - bounded random-number generator: request FSM, rejection sampling, fallback
module lfsr_rng #(
   parameter int           W         = 16,
   parameter logic [W-1:0] TAPS      = W'(lfsr_pkg::DEF_TAPS),
   parameter logic [W-1:0] SEED      = W'(lfsr_pkg::DEF_SEED),
   parameter int           OUT_W     = lfsr_pkg::RND_NUM_W,
   parameter int           MAX_TRIES = 4,
   parameter bit           FREE_RUN  = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             seed_valid_i,
   input  logic [W-1:0]     seed_i,
   input  logic             req_i,
   input  logic [OUT_W-1:0] max_i,
   output logic             ready_o,
   output logic             rnd_valid_o,
   output logic [OUT_W-1:0] rnd_o
);
   import lfsr_pkg::*;

   localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   if (OUT_W > W || W < 3 || MAX_TRIES < 1 || SEED == '0) begin : g_param_check
      $error("lfsr_rng: illegal parameter combination");
   end

   rng_state_t       state, state_nxt;
   logic [W-1:0]     s;
   logic             step;
   logic [OUT_W-1:0] max_q, mask_q, cand, rnd_q;
   logic [TRY_W-1:0] tries;
   logic [CNT_W-1:0] cnt;
   logic             valid_q;
   logic             in_range, retry;
   logic [OUT_W:0]   fallback;
   logic             unused_bits;

   // all ones from the most significant set bit of v downwards
   function automatic logic [OUT_W-1:0] fill_mask(input logic [OUT_W-1:0] v);
      logic [OUT_W-1:0] m;
      m = v;
      for (int i = OUT_W - 2; i >= 0; i--) m[i] = m[i] | m[i+1];
      return m;
   endfunction

   assign cand        = s[OUT_W-1:0] & mask_q;
   assign in_range    = cand <= max_q;
   assign retry       = (int'(tries) + 1) < MAX_TRIES;
   assign fallback    = {1'b0, cand} - ({1'b0, max_q} + 1'b1);
   assign unused_bits = ^{s, fallback[OUT_W]};

   lfsr_core #(
      .W    (W),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_core (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .step_i     (step),
      .load_i     (seed_valid_i),
      .load_val_i (seed_i),
      .state_o    (s)
   );

   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      case (state)
         IDLE: begin
            step = FREE_RUN;
            if (req_i) state_nxt = SHIFT;
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == CNT_W'(OUT_W - 1)) state_nxt = CHECK;
         end
         CHECK: begin
            state_nxt = (in_range || !retry) ? IDLE : SHIFT;
         end
         default: state_nxt = IDLE;
      endcase
      // a seed load aborts any request in flight
      if (seed_valid_i) begin
         state_nxt = IDLE;
         step      = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         max_q   <= '0;
         mask_q  <= '0;
         tries   <= '0;
         cnt     <= '0;
         rnd_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_q <= 1'b0;
         if (!seed_valid_i) begin
            case (state)
               IDLE: begin
                  if (req_i) begin
                     max_q  <= max_i;
                     mask_q <= fill_mask(max_i);
                     tries  <= '0;
                     cnt    <= '0;
                  end
               end
               SHIFT: cnt <= cnt + 1'b1;
               CHECK: begin
                  if (in_range) begin
                     rnd_q   <= cand;
                     valid_q <= 1'b1;
                  end else if (retry) begin
                     tries <= tries + 1'b1;
                     cnt   <= '0;
                  end else begin
                     rnd_q   <= fallback[OUT_W-1:0];
                     valid_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign ready_o     = (state == IDLE);
   assign rnd_valid_o = valid_q;
   assign rnd_o       = rnd_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - self-checking bench for lfsr_rng against a behavioural model
module tb_lfsr_rng;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // instance 0: MAX_TRIES=4, instance 1: MAX_TRIES=1, instance 2: FREE_RUN=1
   logic       sv    [3];
   logic [3:0] seed  [3];
   logic       req   [3];
   logic [1:0] mx    [3];
   logic       ready [3];
   logic       valid [3];
   logic [1:0] rnd   [3];
   logic [3:0] st    [3];
   logic [3:0] ms    [3];

   int errors = 0;
   int checks = 0;

   lfsr_rng #(.W(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(2), .MAX_TRIES(4), .FREE_RUN(1'b0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .seed_valid_i(sv[0]), .seed_i(seed[0]), .req_i(req[0]),
      .max_i(mx[0]), .ready_o(ready[0]), .rnd_valid_o(valid[0]), .rnd_o(rnd[0]));
   lfsr_rng #(.W(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(2), .MAX_TRIES(1), .FREE_RUN(1'b0)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .seed_valid_i(sv[1]), .seed_i(seed[1]), .req_i(req[1]),
      .max_i(mx[1]), .ready_o(ready[1]), .rnd_valid_o(valid[1]), .rnd_o(rnd[1]));
   lfsr_rng #(.W(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(2), .MAX_TRIES(4), .FREE_RUN(1'b1)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .seed_valid_i(sv[2]), .seed_i(seed[2]), .req_i(req[2]),
      .max_i(mx[2]), .ready_o(ready[2]), .rnd_valid_o(valid[2]), .rnd_o(rnd[2]));

   assign st[0] = u_dut0.u_core.state_o;
   assign st[1] = u_dut1.u_core.state_o;
   assign st[2] = u_dut2.u_core.state_o;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // shift left by one, shift in the parity of the tapped bits (taps 4'hC = 12)
   function automatic logic [3:0] step_model(input logic [3:0] s);
      int v;
      v = int'(s);
      return 4'(((v * 2) % 16) + ($countones(v & 12) % 2));
   endfunction

   function automatic int mask_of(input int m);
      int k;
      k = 0;
      while (k < m) k = k * 2 + 1;
      return k;
   endfunction

   task automatic model_req(inout logic [3:0] s, input int m, input int tries_max,
                            output int res, output int n);
      int mk, c;
      mk  = mask_of(m);
      res = -1;
      for (n = 1; n <= tries_max; n++) begin
         s = step_model(step_model(s));
         c = int'(s) & mk;
         if (c <= m) begin res = c; break; end
         if (n == tries_max) begin res = c - (m + 1); break; end
      end
   endtask

   task automatic do_seed(input int d, input int val);
      sv[d]   = 1'b1;
      seed[d] = 4'(val);
      @(posedge clk); @(negedge clk);
      sv[d]   = 1'b0;
      ms[d]   = (val == 0) ? 4'h1 : 4'(val);
      check("seed_load_state", 32'(st[d]), 32'(ms[d]));
   endtask

   task automatic do_req(input int d, input int m, input bit b2b);
      int res, n, lat, low;
      logic [3:0] s;
      s = ms[d];
      model_req(s, m, (d == 1) ? 1 : 4, res, n);
      ms[d]  = s;
      req[d] = 1'b1;
      mx[d]  = 2'(m);
      @(posedge clk); @(negedge clk);
      req[d] = 1'b0;
      mx[d]  = 2'($urandom_range(0, 3));
      lat = 0;
      low = 0;
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) @(negedge clk);
         if (valid[d]) begin lat = k; break; end
         if (!ready[d]) low++;
      end
      check("latency", 32'(lat), 32'(3 * n + 1));
      check("ready_low_cycles", 32'(low), 32'(3 * n));
      check("rnd_value", 32'(rnd[d]), 32'(res));
      check("ready_at_valid", 32'(ready[d]), 32'd1);
      check("lfsr_state", 32'(st[d]), 32'(ms[d]));
      if (!b2b) begin
         @(negedge clk);
         check("valid_one_cycle", 32'(valid[d]), 32'd0);
      end
   endtask

   initial begin
      int vc, first;
      logic [1:0] prev;
      for (int d = 0; d < 3; d++) begin
         sv[d] = 1'b0; seed[d] = 4'h0; req[d] = 1'b0; mx[d] = 2'd0; ms[d] = 4'h1;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_ready", 32'(ready[d]), 32'd1);
         check("reset_valid", 32'(valid[d]), 32'd0);
         check("reset_rnd", 32'(rnd[d]), 32'd0);
         check("reset_state", 32'(st[d]), 32'h1);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // directed draws from the reset seed
      do_req(0, 3, 1'b0);
      do_req(0, 3, 1'b0);
      do_req(0, 2, 1'b0);

      // one rejected draw then accept
      do_seed(0, 4);
      do_req(0, 2, 1'b0);

      // single-try fallback
      do_seed(1, 4);
      do_req(1, 2, 1'b0);

      // zero seed substitution and full period in free-run
      do_seed(2, 0);
      first = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         ms[2] = step_model(ms[2]);
         check("free_run_state", 32'(st[2]), 32'(ms[2]));
         check("free_run_nonzero", 32'(st[2] != 4'h0), 32'd1);
         if (st[2] == 4'h1 && first == 0) first = i;
      end
      check("period", 32'(first), 32'd15);

      // abort during SHIFT
      prev   = rnd[0];
      req[0] = 1'b1; mx[0] = 2'd3;
      @(posedge clk); @(negedge clk);
      req[0] = 1'b0;
      do_seed(0, 7);
      check("abort_shift_ready", 32'(ready[0]), 32'd1);
      check("abort_shift_valid", 32'(valid[0]), 32'd0);
      check("abort_shift_rnd", 32'(rnd[0]), 32'(prev));
      vc = 0;
      repeat (8) begin @(negedge clk); if (valid[0]) vc++; end
      check("abort_shift_no_pulse", 32'(vc), 32'd0);

      // abort coinciding with CHECK
      req[0] = 1'b1; mx[0] = 2'd1;
      @(posedge clk); @(negedge clk);
      req[0] = 1'b0;
      repeat (2) @(negedge clk);
      do_seed(0, 9);
      check("abort_check_valid", 32'(valid[0]), 32'd0);
      check("abort_check_ready", 32'(ready[0]), 32'd1);
      check("abort_check_rnd", 32'(rnd[0]), 32'(prev));

      // randomized requests with occasional reseeds and back-to-back accepts
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 5) == 0) do_seed(0, int'($urandom_range(0, 15)));
         do_req(0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 2) == 0) do_seed(1, int'($urandom_range(0, 15)));
         do_req(1, int'($urandom_range(0, 3)), 1'b0);
      end

      // asynchronous reset mid-request
      req[0] = 1'b1; mx[0] = 2'd3;
      @(posedge clk); @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_ready", 32'(ready[0]), 32'd1);
      check("async_rst_valid", 32'(valid[0]), 32'd0);
      check("async_rst_rnd", 32'(rnd[0]), 32'd0);
      check("async_rst_state", 32'(st[0]), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      ms[0] = 4'h1;
      vc = 0;
      repeat (6) begin @(negedge clk); if (valid[0]) vc++; end
      check("async_rst_no_pulse", 32'(vc), 32'd0);
      do_req(0, 3, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
